// File: rtl/sync_fifo_param.sv
// Single-clock parametrised FIFO with registered read port, programmable
// almost-full/almost-empty thresholds, occupancy count and sticky error flags.
module sync_fifo_param #(
    parameter int DATA_WIDTH          = 16,
    parameter int ADDR_WIDTH          = 6,
    parameter int ALMOST_FULL_THRESH  = 56,
    parameter int ALMOST_EMPTY_THRESH = 8
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  write_enable,
    input  logic [DATA_WIDTH-1:0] write_data,
    input  logic                  read_enable,
    output logic [DATA_WIDTH-1:0] read_data,
    output logic                  read_valid,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  overflow,
    output logic                  underflow,
    input  logic                  clear_errors
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    localparam logic [ADDR_WIDTH:0]   COUNT_ONE  = (ADDR_WIDTH+1)'(1);
    localparam logic [ADDR_WIDTH-1:0] PTR_ONE    = ADDR_WIDTH'(1);
    localparam logic [ADDR_WIDTH:0]   FULL_LEVEL = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0]   AF_LEVEL   = (ADDR_WIDTH+1)'(ALMOST_FULL_THRESH);
    localparam logic [ADDR_WIDTH:0]   AE_LEVEL   = (ADDR_WIDTH+1)'(ALMOST_EMPTY_THRESH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] rd_ptr;

    logic                  write_accept;
    logic                  read_accept;
    logic [ADDR_WIDTH:0]   count_next;

    // Accepts use the registered flags, so a full FIFO still takes a read
    // and an empty FIFO still takes a write on the same edge.
    always_comb begin
        write_accept = write_enable && !full;
        read_accept  = read_enable && !empty;
        count_next   = count;
        if (write_accept && !read_accept) begin
            count_next = count + COUNT_ONE;
        end else if (read_accept && !write_accept) begin
            count_next = count - COUNT_ONE;
        end
    end

    // Storage is deliberately left out of reset.
    always_ff @(posedge clock) begin
        if (write_accept) begin
            mem[wr_ptr] <= write_data;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (write_accept) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (read_accept) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            count <= count_next;
        end
    end

    // Status flags come from the next count so they move on the same edge
    // as count without any combinational path from the enables.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            full         <= 1'b0;
            empty        <= 1'b1;
            almost_full  <= 1'b0;
            almost_empty <= 1'b1;
        end else begin
            full         <= (count_next == FULL_LEVEL);
            empty        <= (count_next == '0);
            almost_full  <= (count_next >= AF_LEVEL);
            almost_empty <= (count_next <= AE_LEVEL);
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            read_data  <= '0;
            read_valid <= 1'b0;
        end else begin
            read_valid <= read_accept;
            if (read_accept) begin
                read_data <= mem[rd_ptr];
            end
        end
    end

    // A new error on the same edge as clear_errors keeps the flag set.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            overflow  <= (overflow && !clear_errors) || (write_enable && full);
            underflow <= (underflow && !clear_errors) || (read_enable && empty);
        end
    end

endmodule

// File: tb/tb_sync_fifo_param.sv
// Self-checking bench for sync_fifo_param: directed vector table, test-plan
// sequences and randomized traffic against a queue-based reference model.
module tb_sync_fifo_param;

    localparam int DW    = 16;
    localparam int AW    = 6;
    localparam int DEPTH = 64;
    localparam int AFT   = 56;
    localparam int AET   = 8;

    logic          clock = 1'b0;
    logic          reset_n;
    logic          write_enable;
    logic [DW-1:0] write_data;
    logic          read_enable;
    logic          clear_errors;
    logic [DW-1:0] read_data;
    logic          read_valid;
    logic          full;
    logic          empty;
    logic          almost_full;
    logic          almost_empty;
    logic [AW:0]   count;
    logic          overflow;
    logic          underflow;

    int total_checks = 0;
    int bad_checks   = 0;

    logic [DW-1:0] model_q [$];
    logic [DW-1:0] model_rdata;
    logic          model_valid;
    logic          model_ovf;
    logic          model_unf;

    typedef struct {
        logic          we;
        logic [DW-1:0] wd;
        logic          re;
        logic          clr;
        logic [AW:0]   exp_count;
        logic          exp_valid;
        logic [DW-1:0] exp_rdata;
        logic          exp_ovf;
        logic          exp_unf;
    } vec_t;

    vec_t vectors [10];

    sync_fifo_param #(
        .DATA_WIDTH          (DW),
        .ADDR_WIDTH          (AW),
        .ALMOST_FULL_THRESH  (AFT),
        .ALMOST_EMPTY_THRESH (AET)
    ) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .write_enable (write_enable),
        .write_data   (write_data),
        .read_enable  (read_enable),
        .read_data    (read_data),
        .read_valid   (read_valid),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .count        (count),
        .overflow     (overflow),
        .underflow    (underflow),
        .clear_errors (clear_errors)
    );

    always #5 clock = ~clock;

    task automatic checkValue(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total_checks++;
        if (actual !== expected) begin
            bad_checks++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic modelReset();
        model_q.delete();
        model_rdata = '0;
        model_valid = 1'b0;
        model_ovf   = 1'b0;
        model_unf   = 1'b0;
    endtask

    // Reference behaviour from the pre-edge occupancy: pop before push.
    task automatic stepModel();
        int  size;
        bit  wacc;
        bit  racc;
        size = model_q.size();
        wacc = write_enable && (size < DEPTH);
        racc = read_enable && (size > 0);
        model_ovf = (model_ovf && !clear_errors) || (write_enable && size == DEPTH);
        model_unf = (model_unf && !clear_errors) || (read_enable && size == 0);
        if (racc) begin
            model_rdata = model_q.pop_front();
            model_valid = 1'b1;
        end else begin
            model_valid = 1'b0;
        end
        if (wacc) begin
            model_q.push_back(write_data);
        end
    endtask

    task automatic applyStimulus(input logic we, input logic [DW-1:0] wd, input logic re, input logic clr);
        write_enable = we;
        write_data   = wd;
        read_enable  = re;
        clear_errors = clr;
        @(posedge clock);
        stepModel();
        #1;
        write_enable = 1'b0;
        read_enable  = 1'b0;
        clear_errors = 1'b0;
    endtask

    task automatic checkOutput(input string tag);
        int n;
        n = model_q.size();
        checkValue({tag, ".count"},        32'(count),        32'(n));
        checkValue({tag, ".full"},         32'(full),         32'(n == DEPTH));
        checkValue({tag, ".empty"},        32'(empty),        32'(n == 0));
        checkValue({tag, ".almost_full"},  32'(almost_full),  32'(n >= AFT));
        checkValue({tag, ".almost_empty"}, 32'(almost_empty), 32'(n <= AET));
        checkValue({tag, ".read_valid"},   32'(read_valid),   32'(model_valid));
        checkValue({tag, ".read_data"},    32'(read_data),    32'(model_rdata));
        checkValue({tag, ".overflow"},     32'(overflow),     32'(model_ovf));
        checkValue({tag, ".underflow"},    32'(underflow),    32'(model_unf));
    endtask

    initial begin
        #1_000_000;
        bad_checks++;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $display("test done: total=%0d bad=%0d", total_checks, bad_checks);
        $finish;
    end

    initial begin
        int bias_w;
        int bias_r;

        vectors[0] = '{1'b0, 16'h0000, 1'b0, 1'b0, 7'd0, 1'b0, 16'h0000, 1'b0, 1'b0};
        vectors[1] = '{1'b0, 16'h0000, 1'b1, 1'b0, 7'd0, 1'b0, 16'h0000, 1'b0, 1'b1};
        vectors[2] = '{1'b1, 16'hA5A5, 1'b0, 1'b0, 7'd1, 1'b0, 16'h0000, 1'b0, 1'b1};
        vectors[3] = '{1'b1, 16'h5A5A, 1'b0, 1'b1, 7'd2, 1'b0, 16'h0000, 1'b0, 1'b0};
        vectors[4] = '{1'b1, 16'h1234, 1'b1, 1'b0, 7'd2, 1'b1, 16'hA5A5, 1'b0, 1'b0};
        vectors[5] = '{1'b0, 16'h0000, 1'b1, 1'b0, 7'd1, 1'b1, 16'h5A5A, 1'b0, 1'b0};
        vectors[6] = '{1'b0, 16'h0000, 1'b1, 1'b0, 7'd0, 1'b1, 16'h1234, 1'b0, 1'b0};
        vectors[7] = '{1'b0, 16'h0000, 1'b0, 1'b0, 7'd0, 1'b0, 16'h1234, 1'b0, 1'b0};
        vectors[8] = '{1'b1, 16'hBEEF, 1'b1, 1'b0, 7'd1, 1'b0, 16'h1234, 1'b0, 1'b1};
        vectors[9] = '{1'b0, 16'h0000, 1'b1, 1'b1, 7'd0, 1'b1, 16'hBEEF, 1'b0, 1'b0};

        reset_n      = 1'b0;
        write_enable = 1'b0;
        write_data   = '0;
        read_enable  = 1'b0;
        clear_errors = 1'b0;
        modelReset();
        repeat (2) @(posedge clock);
        #1;
        checkOutput("in_reset");
        reset_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, '0, 1'b0, 1'b0);
            checkOutput("idle");
        end

        $display("[TB] directed vector table");
        for (int i = 0; i < 10; i++) begin
            applyStimulus(vectors[i].we, vectors[i].wd, vectors[i].re, vectors[i].clr);
            checkValue($sformatf("vec%0d.count", i),      32'(count),      32'(vectors[i].exp_count));
            checkValue($sformatf("vec%0d.empty", i),      32'(empty),      32'(vectors[i].exp_count == 0));
            checkValue($sformatf("vec%0d.read_valid", i), 32'(read_valid), 32'(vectors[i].exp_valid));
            checkValue($sformatf("vec%0d.read_data", i),  32'(read_data),  32'(vectors[i].exp_rdata));
            checkValue($sformatf("vec%0d.overflow", i),   32'(overflow),   32'(vectors[i].exp_ovf));
            checkValue($sformatf("vec%0d.underflow", i),  32'(underflow),  32'(vectors[i].exp_unf));
        end

        $display("[TB] fill to full and overflow");
        for (int i = 0; i < DEPTH; i++) begin
            applyStimulus(1'b1, 16'(16'h1000 + i), 1'b0, 1'b0);
            checkOutput("fill");
            checkValue("fill.almost_empty_edge", 32'(almost_empty), 32'((i + 1) <= 8));
            checkValue("fill.almost_full_edge",  32'(almost_full),  32'((i + 1) >= 56));
        end
        checkValue("fill.full_at_64", 32'(full), 32'd1);
        checkValue("fill.count_64",   32'(count), 32'd64);
        applyStimulus(1'b1, 16'hDEAD, 1'b0, 1'b0);
        checkOutput("overflow_write");
        checkValue("overflow.set",   32'(overflow), 32'd1);
        checkValue("overflow.count", 32'(count),    32'd64);

        $display("[TB] drain and underflow");
        for (int i = 0; i < DEPTH; i++) begin
            applyStimulus(1'b0, '0, 1'b1, 1'b0);
            checkOutput("drain");
            checkValue("drain.order", 32'(read_data), 32'(16'h1000 + i));
        end
        checkValue("drain.empty", 32'(empty), 32'd1);
        applyStimulus(1'b0, '0, 1'b1, 1'b0);
        checkOutput("underflow_read");
        checkValue("underflow.set",      32'(underflow),  32'd1);
        checkValue("underflow.no_valid", 32'(read_valid), 32'd0);
        applyStimulus(1'b0, '0, 1'b0, 1'b1);
        checkOutput("clear1");

        $display("[TB] simultaneous read/write at count 10");
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b1, 16'(16'h2000 + i), 1'b0, 1'b0);
            checkOutput("prefill");
        end
        for (int i = 0; i < 20; i++) begin
            applyStimulus(1'b1, 16'(16'h3000 + i), 1'b1, 1'b0);
            checkOutput("rw10");
            checkValue("rw10.count_steady", 32'(count), 32'd10);
        end
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b0, '0, 1'b1, 1'b0);
            checkOutput("rw10_drain");
        end
        applyStimulus(1'b1, 16'h4444, 1'b1, 1'b0);
        checkOutput("rw_empty");
        checkValue("rw_empty.count",     32'(count),      32'd1);
        checkValue("rw_empty.underflow", 32'(underflow),  32'd1);
        checkValue("rw_empty.no_valid",  32'(read_valid), 32'd0);
        applyStimulus(1'b0, '0, 1'b1, 1'b1);
        checkOutput("rw_empty_drain");

        $display("[TB] pointer wrap-around");
        for (int pass = 0; pass < 2; pass++) begin
            for (int i = 0; i < 40; i++) begin
                applyStimulus(1'b1, 16'($urandom), 1'b0, 1'b0);
                checkOutput("wrap_write");
            end
            for (int i = 0; i < 40; i++) begin
                applyStimulus(1'b0, '0, 1'b1, 1'b0);
                checkOutput("wrap_read");
            end
        end
        checkValue("wrap.no_overflow",  32'(overflow),  32'd0);
        checkValue("wrap.no_underflow", 32'(underflow), 32'd0);
        applyStimulus(1'b0, '0, 1'b1, 1'b0);
        checkOutput("wrap_underflow");
        applyStimulus(1'b0, '0, 1'b0, 1'b1);
        checkOutput("clear2");
        checkValue("clear.underflow", 32'(underflow), 32'd0);
        checkValue("clear.overflow",  32'(overflow),  32'd0);

        $display("[TB] asynchronous reset at count 20");
        for (int i = 0; i < 20; i++) begin
            applyStimulus(1'b1, 16'(16'h5000 + i), 1'b0, 1'b0);
        end
        checkOutput("pre_reset");
        reset_n = 1'b0;
        #2;
        modelReset();
        checkOutput("async_reset");
        #2;
        reset_n = 1'b1;
        applyStimulus(1'b0, '0, 1'b1, 1'b0);
        checkOutput("post_reset_read");
        checkValue("post_reset.underflow", 32'(underflow),  32'd1);
        checkValue("post_reset.no_valid",  32'(read_valid), 32'd0);

        $display("[TB] randomized traffic");
        for (int i = 0; i < 3000; i++) begin
            case ((i / 300) % 4)
                0:       begin bias_w = 80; bias_r = 20; end
                1:       begin bias_w = 20; bias_r = 80; end
                2:       begin bias_w = 50; bias_r = 50; end
                default: begin bias_w = 65; bias_r = 45; end
            endcase
            applyStimulus(($urandom_range(0, 99) < bias_w),
                          16'($urandom),
                          ($urandom_range(0, 99) < bias_r),
                          ($urandom_range(0, 39) == 0));
            checkOutput("random");
        end

        $display("test done: total=%0d bad=%0d", total_checks, bad_checks);
        $finish;
    end

endmodule
